// File: rtl/instr_mem_loader_pkg.sv
// Shared geometry and loader state encodings for the RISC16 instruction memory loader.
// State codes are exported so debug/status logic can decode the loader state directly.
package instr_mem_loader_pkg;

    localparam int COLS   = 16;
    localparam int ROWS_I = 16;
    localparam int BYTE_W = 8;

    localparam logic [2:0] LD_IDLE = 3'd0;
    localparam logic [2:0] LD_HDR  = 3'd1;
    localparam logic [2:0] LD_HI   = 3'd2;
    localparam logic [2:0] LD_LO   = 3'd3;
    localparam logic [2:0] LD_CHK  = 3'd4;

    // A frame may carry between 1 and depth words inclusive.
    function automatic logic count_ok(input logic [BYTE_W-1:0] cnt, input int depth);
        return (cnt != '0) && (int'(cnt) <= depth);
    endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Byte-stream loader: COUNT, COUNT x (HI, LO), CHK -> 16-bit writes into instruction memory.
// Writes land one cycle after the LO byte; in_ready depends only on state and abort.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = COLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] word_idx;
    logic [7:0]        hi_q;
    logic [7:0]        csum;
    logic              accept;
    logic              last_word;
    logic              hdr_ok;

    assign in_ready  = (state != LD_IDLE) && !abort;
    assign accept    = in_valid && in_ready;
    assign last_word = (CNT_W'(word_idx) + CNT_W'(1)) == count_q;
    assign hdr_ok    = count_ok(in_data, DEPTH);

    always_comb begin
        state_nxt = state;
        case (state)
            LD_IDLE: if (load_start) state_nxt = LD_HDR;
            LD_HDR:  if (accept) state_nxt = hdr_ok ? LD_HI : LD_IDLE;
            LD_HI:   if (accept) state_nxt = LD_LO;
            LD_LO:   if (accept) state_nxt = last_word ? LD_CHK : LD_HI;
            LD_CHK:  if (accept) state_nxt = LD_IDLE;
            default: state_nxt = LD_IDLE;
        endcase
        // Abort only matters mid-load; in IDLE a coincident load_start wins.
        if ((state != LD_IDLE) && abort) state_nxt = LD_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LD_IDLE;
            cpu_hold  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            count_q   <= '0;
            word_idx  <= '0;
            hi_q      <= '0;
            csum      <= '0;
        end else begin
            state    <= state_nxt;
            cpu_hold <= (state_nxt != LD_IDLE);
            mem_we   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (accept) begin
                case (state)
                    LD_HDR: begin
                        if (hdr_ok) begin
                            count_q  <= in_data[CNT_W-1:0];
                            word_idx <= '0;
                            csum     <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    LD_HI: begin
                        hi_q <= in_data;
                        csum <= csum + in_data;
                    end
                    LD_LO: begin
                        csum      <= csum + in_data;
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx;
                        mem_wdata <= {hi_q, in_data};
                        // Index saturates at COUNT-1 so a full-depth frame never wraps.
                        if (!last_word) word_idx <= word_idx + ADDR_W'(1);
                    end
                    LD_CHK: begin
                        if (in_data == csum) done <= 1'b1;
                        else                 err  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a write scoreboard checked on the falling edge.
module tb_instr_mem_loader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              load_start = 1'b0;
    logic              abort      = 1'b0;
    logic [7:0]        in_data    = 8'h00;
    logic              in_valid   = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int n_checks   = 0;
    int n_pass     = 0;
    int n_fail     = 0;
    int done_seen  = 0;
    int err_seen   = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                check("wr_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(mon_e[19:16]));
                    check("wr_data", 32'(mem_wdata), 32'(mon_e[15:0]));
                end
            end
            if (done || err) check("hold_drop", 32'(cpu_hold), 0);
            if (done) done_seen++;
            if (err)  err_seen++;
        end
    end

    task automatic start_load();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        check("hold_after_start", 32'(cpu_hold), 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 1);
        else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cnt, input logic [15:0] words[$],
                              input logic [7:0] chk, input bit rnd);
        start_load();
        send_byte(cnt, rnd);
        for (int i = 0; i < words.size(); i++) begin
            send_byte(words[i][15:8], rnd);
            exp_q.push_back({i[3:0], words[i]});
            send_byte(words[i][7:0], rnd);
        end
        send_byte(chk, rnd);
    endtask

    task automatic expect_status(input string tag, input logic d, input logic e);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_err"},  32'(err),  32'(e));
        check({tag, "_hold"}, 32'(cpu_hold), 0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(done | err), 0);
        check({tag, "_drain"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        logic [15:0] f1[$];
        logic [15:0] f4[$];
        logic [7:0]  c4;
        logic [7:0]  b;

        #2;
        check("rst_hold",  32'(cpu_hold), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_we",    32'(mem_we), 0);
        check("rst_done",  32'(done), 0);
        check("rst_err",   32'(err), 0);
        check("rst_addr",  32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        #20 rst = 1'b0;
        @(posedge clk); #1;

        f1 = '{16'h1234, 16'hABCD};

        // Basic two-word load with good checksum
        send_frame(8'h02, f1, 8'hBE, 1'b0);
        expect_status("t1", 1'b1, 1'b0);

        // Bad checksum: writes still occur
        send_frame(8'h02, f1, 8'hBF, 1'b0);
        expect_status("t2", 1'b0, 1'b1);

        // Illegal COUNT values
        start_load();
        send_byte(8'h00, 1'b0);
        check("t3a_ready_idle", 32'(in_ready), 0);
        expect_status("t3a", 1'b0, 1'b1);
        start_load();
        send_byte(8'h11, 1'b0);
        check("t3b_ready_idle", 32'(in_ready), 0);
        expect_status("t3b", 1'b0, 1'b1);

        // Full-depth load
        c4 = 8'h00;
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            f4.push_back({b, ~b});
            c4 = c4 + b + ~b;
        end
        send_frame(8'h10, f4, c4, 1'b0);
        expect_status("t4", 1'b1, 1'b0);

        // Random valid stalls
        send_frame(8'h02, f1, 8'hBE, 1'b1);
        expect_status("t5", 1'b1, 1'b0);

        // Abort while the first word is being written
        start_load();
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        exp_q.push_back({4'h0, 16'h1234});
        send_byte(8'h34, 1'b0);
        check("t6_we_now", 32'(mem_we), 1);
        abort = 1'b1;
        #1 check("t6_ready_abort", 32'(in_ready), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("t6_hold", 32'(cpu_hold), 0);
        check("t6_ready", 32'(in_ready), 0);
        check("t6_we_after", 32'(mem_we), 0);
        @(posedge clk); #1;
        check("t6_drain", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-HI
        start_load();
        send_byte(8'h02, 1'b0);
        in_data  = 8'h12;
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("t6r_hold",  32'(cpu_hold), 0);
        check("t6r_ready", 32'(in_ready), 0);
        check("t6r_we",    32'(mem_we), 0);
        check("t6r_wdata", 32'(mem_wdata), 0);
        check("t6r_addr",  32'(mem_addr), 0);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;

        send_frame(8'h02, f1, 8'hBE, 1'b0);
        expect_status("t6n", 1'b1, 1'b0);

        @(posedge clk); #1;
        check("total_done", 32'(done_seen), 4);
        check("total_err",  32'(err_seen), 3);
        check("final_drain", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
